// File: rtl/hazard_ctrl_if.sv
// Hazard controller pipeline interface.
// Bundles the hazard-detection inputs from the datapath with the stall,
// bubble and flush controls that go back to the pipeline registers.
// The master side is the pipeline/datapath, and the slave side is hazard_ctrl.
interface hazard_ctrl_if;
    // Hazard sources observed in the pipeline.
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic [4:0] ex_rd_i;
    logic       ex_mem_re_i;
    logic       branch_taken_i;
    logic       mem_req_i;
    logic       mem_ready_i;

    // Sequencing controls for the pipeline registers.
    logic       stall_if_o;
    logic       stall_id_o;
    logic       stall_ex_o;
    logic       bubble_ex_o;
    logic       flush_if_o;
    logic       flush_id_o;

    modport master (
        output id_rs1_i, id_rs2_i, ex_rd_i, ex_mem_re_i,
               branch_taken_i, mem_req_i, mem_ready_i,
        input  stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o,
               flush_if_o, flush_id_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, ex_rd_i, ex_mem_re_i,
               branch_taken_i, mem_req_i, mem_ready_i,
        output stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o,
               flush_if_o, flush_id_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// This module handles three jobs. It inserts one bubble on a load-use hazard.
// It freezes the pipe while a data-memory access is outstanding. It flushes
// IF and ID for 1+FLUSH_EXTRA cycles after a taken branch.
// All controls are Mealy outputs. They are forced low while reset is held.
// The module also counts the cycles in which decode is stalled. That count
// saturates instead of wrapping.
module hazard_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     hz,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_EXTRA);
    localparam bit         HAS_FLUSH   = (FLUSH_EXTRA > 0);

    logic [1:0]       state_q, state_d;
    logic [2:0]       flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    logic luHazard;
    logic memWait;
    logic stallIf;
    logic stallId;
    logic stallEx;
    logic bubbleEx;
    logic flushIf;
    logic flushId;

    // A load in EX feeds a source of the instruction in ID. x0 is never a
    // hazard source. An unused rs2 arrives as 0, so no opcode decode is needed.
    assign luHazard = hz.ex_mem_re_i
                    & (hz.ex_rd_i != 5'd0)
                    & ((hz.ex_rd_i == hz.id_rs1_i) | (hz.ex_rd_i == hz.id_rs2_i));

    // The data memory holds MEM this cycle. This has the highest priority.
    assign memWait = hz.mem_req_i & ~hz.mem_ready_i;

    // Next-state and Mealy control decode. The priority order is
    // memory wait, then branch, then load-use.
    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        stallIf    = 1'b0;
        stallId    = 1'b0;
        stallEx    = 1'b0;
        bubbleEx   = 1'b0;
        flushIf    = 1'b0;
        flushId    = 1'b0;

        case (state_q)
            ST_RUN, ST_LU_STALL, ST_MEM_WAIT: begin
                if (memWait) begin
                    stallIf = 1'b1;
                    stallId = 1'b1;
                    stallEx = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (state_q == ST_LU_STALL) begin
                    // The single bubble is already in EX, so the load has
                    // moved on. Do not re-check the hazard in this cycle.
                    state_d = ST_RUN;
                end else if (hz.branch_taken_i) begin
                    // This branch also covers a taken branch held in EX while
                    // a memory wait was in progress.
                    flushIf = 1'b1;
                    flushId = 1'b1;
                    if (HAS_FLUSH) begin
                        state_d    = ST_FLUSH;
                        flushCnt_d = FLUSH_LOAD;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end else if (luHazard) begin
                    stallIf  = 1'b1;
                    stallId  = 1'b1;
                    bubbleEx = 1'b1;
                    state_d  = ST_LU_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                // The EX instruction has already been killed. A branch_taken_i
                // seen here is stale, so it is ignored.
                flushIf = 1'b1;
                flushId = 1'b1;
                if (memWait) begin
                    stallEx = 1'b1;
                end else begin
                    flushCnt_d = flushCnt_q - 3'd1;
                    if (flushCnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter. It counts every cycle in which decode
    // is held.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallId && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // State, flush countdown and performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            flushCnt_q <= 3'd0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // All outputs are held at zero while reset is asserted. This also
    // applies to the combinational controls, so no stale stall or flush
    // reaches the pipeline during reset.
    assign hz.stall_if_o  = rst_n & stallIf;
    assign hz.stall_id_o  = rst_n & stallId;
    assign hz.stall_ex_o  = rst_n & stallEx;
    assign hz.bubble_ex_o = rst_n & bubbleEx;
    assign hz.flush_if_o  = rst_n & flushIf;
    assign hz.flush_id_o  = rst_n & flushId;
    assign state_o        = rst_n ? state_q : ST_RUN;
    assign stall_cnt_o    = rst_n ? stallCnt_q : '0;

    // Decode is never held and killed in the same cycle.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(stallId && flushId));

    // A bubble goes into EX only while EX advances.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bubbleEx && stallEx));

    // Every cycle in the FLUSH state kills both front-end stages.
    assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_FLUSH) |-> (flushIf && flushId));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl.
// This bench drives two instances with the same inputs. The first uses
// FLUSH_EXTRA=1 and CNT_W=32. The second uses FLUSH_EXTRA=3 and CNT_W=4, so
// its counter saturates quickly. Each DUT is compared every cycle against a
// behavioural model of the sequencing rules.
module tb_hazard_ctrl;

    localparam int FX_A = 1;
    localparam int CW_A = 32;
    localparam int FX_B = 3;
    localparam int CW_B = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    hazard_ctrl_if ifA ();
    hazard_ctrl_if ifB ();

    logic [1:0]      stateA, stateB;
    logic [CW_A-1:0] cntA;
    logic [CW_B-1:0] cntB;

    hazard_ctrl #(.FLUSH_EXTRA(FX_A), .CNT_W(CW_A)) dutA (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (ifA),
        .state_o     (stateA),
        .stall_cnt_o (cntA)
    );

    hazard_ctrl #(.FLUSH_EXTRA(FX_B), .CNT_W(CW_B)) dutB (
        .clk         (clk),
        .rst_n       (rst_n),
        .hz          (ifB),
        .state_o     (stateB),
        .stall_cnt_o (cntB)
    );

    typedef struct {
        bit sif, sid, sex, bub, fif, fid;
        int st;
        int nFlush;
        bit nMem, nBub;
    } step_t;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    logic [4:0] rs1, rs2, rd;
    bit load, br, req, ready;

    // Model state. The model uses remaining flush cycles, a pending memory
    // wait and a just-bubbled flag instead of an encoded state.
    int     mFlush [2];
    bit     mMem   [2];
    bit     mBub   [2];
    longint mCnt   [2];
    int     fx     [2] = '{FX_A, FX_B};
    longint cap    [2] = '{(64'd1 << CW_A) - 1, (64'd1 << CW_B) - 1};
    string  nm     [2] = '{"A", "B"};

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        testsRun++;
        if (obs != expv) begin
            testsFailed++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", tag, cycle, obs, expv);
        end
    endtask

    task automatic driveInputs();
        ifA.id_rs1_i = rs1;   ifB.id_rs1_i = rs1;
        ifA.id_rs2_i = rs2;   ifB.id_rs2_i = rs2;
        ifA.ex_rd_i = rd;     ifB.ex_rd_i = rd;
        ifA.ex_mem_re_i = load;    ifB.ex_mem_re_i = load;
        ifA.branch_taken_i = br;   ifB.branch_taken_i = br;
        ifA.mem_req_i = req;       ifB.mem_req_i = req;
        ifA.mem_ready_i = ready;   ifB.mem_ready_i = ready;
    endtask

    // Expected behaviour for the current inputs and model state.
    function automatic step_t modelStep(int k);
        step_t s;
        bit lu;
        bit mw;
        s = '{default: 0};
        lu = load && (rd != 0) && (rd == rs1 || rd == rs2);
        mw = req && !ready;
        s.st = (mFlush[k] > 0) ? 3 : mMem[k] ? 2 : mBub[k] ? 1 : 0;
        s.nFlush = mFlush[k];
        if (mFlush[k] > 0) begin
            s.fif = 1; s.fid = 1; s.sex = mw;
            if (!mw) s.nFlush = mFlush[k] - 1;
        end else if (mw) begin
            s.sif = 1; s.sid = 1; s.sex = 1; s.nMem = 1;
        end else if (mBub[k]) begin
            s.nBub = 0;
        end else if (br) begin
            s.fif = 1; s.fid = 1; s.nFlush = fx[k];
        end else if (lu) begin
            s.sif = 1; s.sid = 1; s.bub = 1; s.nBub = 1;
        end
        return s;
    endfunction

    function automatic step_t observe(int k);
        step_t o;
        o = '{default: 0};
        if (k == 0) begin
            o.sif = ifA.stall_if_o; o.sid = ifA.stall_id_o; o.sex = ifA.stall_ex_o;
            o.bub = ifA.bubble_ex_o; o.fif = ifA.flush_if_o; o.fid = ifA.flush_id_o;
            o.st = int'(stateA);
        end else begin
            o.sif = ifB.stall_if_o; o.sid = ifB.stall_id_o; o.sex = ifB.stall_ex_o;
            o.bub = ifB.bubble_ex_o; o.fif = ifB.flush_if_o; o.fid = ifB.flush_id_o;
            o.st = int'(stateB);
        end
        return o;
    endfunction

    function automatic longint observeCnt(int k);
        return (k == 0) ? longint'(cntA) : longint'(cntB);
    endfunction

    task automatic compareAll(input int k, input step_t e, input longint ecnt);
        step_t o;
        o = observe(k);
        checkOutput({nm[k], ".stall_if"},  o.sif, e.sif);
        checkOutput({nm[k], ".stall_id"},  o.sid, e.sid);
        checkOutput({nm[k], ".stall_ex"},  o.sex, e.sex);
        checkOutput({nm[k], ".bubble_ex"}, o.bub, e.bub);
        checkOutput({nm[k], ".flush_if"},  o.fif, e.fif);
        checkOutput({nm[k], ".flush_id"},  o.fid, e.fid);
        checkOutput({nm[k], ".state"},     o.st,  e.st);
        checkOutput({nm[k], ".stall_cnt"}, observeCnt(k), ecnt);
    endtask

    // Run one cycle. Inputs are applied after the falling edge, outputs are
    // checked shortly after that, and the model advances on the rising edge.
    task automatic applyStimulus(input logic [4:0] aRs1, input logic [4:0] aRs2,
                                 input logic [4:0] aRd, input bit aLoad, input bit aBr,
                                 input bit aReq, input bit aReady);
        step_t e [2];
        @(negedge clk);
        rs1 = aRs1; rs2 = aRs2; rd = aRd;
        load = aLoad; br = aBr; req = aReq; ready = aReady;
        driveInputs();
        #2;
        for (int k = 0; k < 2; k++) begin
            e[k] = modelStep(k);
            compareAll(k, e[k], mCnt[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mFlush[k] = e[k].nFlush;
            mMem[k]   = e[k].nMem;
            mBub[k]   = e[k].nBub;
            if (e[k].sid && mCnt[k] < cap[k]) mCnt[k]++;
        end
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    endtask

    // Assert reset with the current inputs still applied. Every output must
    // drop to zero at once. The bench then returns to an idle pipeline.
    task automatic applyReset();
        step_t z;
        z = '{default: 0};
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compareAll(0, z, 0);
        compareAll(1, z, 0);
        rs1 = 0; rs2 = 0; rd = 0; load = 0; br = 0; req = 0; ready = 1;
        driveInputs();
        for (int k = 0; k < 2; k++) begin
            mFlush[k] = 0; mMem[k] = 0; mBub[k] = 0; mCnt[k] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rs1 = 0; rs2 = 0; rd = 0; load = 0; br = 0; req = 0; ready = 1;
        driveInputs();
        applyReset();

        // Load-use on rs1 inserts a single bubble.
        applyStimulus(5, 0, 5, 1, 0, 0, 1);
        idle(2);
        checkOutput("A.lu_cnt", longint'(cntA), 1);

        // A load to x0 is never a hazard.
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(3, 7, 7, 1, 0, 0, 1);
        idle(2);

        // A three-cycle memory wait.
        applyReset();
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        idle(1);
        checkOutput("A.mw_cnt", longint'(cntA), 3);

        // A single taken-branch pulse.
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        idle(4);

        // A branch and a load-use in the same cycle: the branch wins.
        applyStimulus(4, 0, 4, 1, 1, 0, 1);
        idle(4);

        // A memory wait that ends with a branch held in EX, then a flush
        // interrupted by a memory wait.
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(4);

        // A memory wait during the load-use bubble cycle.
        applyStimulus(2, 0, 2, 1, 0, 0, 1);
        applyStimulus(2, 0, 2, 1, 0, 1, 0);
        applyStimulus(2, 0, 2, 1, 0, 1, 1);
        idle(2);

        // Reset in the middle of a memory wait.
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyReset();
        idle(2);

        // A long stall that saturates the 4-bit counter.
        repeat (20) applyStimulus(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        checkOutput("B.cnt_sat", longint'(cntB), 15);
        checkOutput("A.cnt_20", longint'(cntA), 20);

        // Random traffic with a small register space so that hazards are
        // frequent, plus occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) applyReset();
            applyStimulus(5'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
